// File: rtl/pixel_scan_gen.sv
// Raster scan generator: walks a frame pixel by pixel and emits screen plus complex-plane coordinates.
// Optional abort input is compiled in when SCAN_ABORT_EN is defined.
module pixel_scan_gen #(
  parameter int Q     = 21,
  parameter int N     = 32,
  parameter int H_RES = 640,
  parameter int V_RES = 480,
  parameter int STEP0 = 9830
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] start_coord_X,
  input  logic [N-1:0] start_coord_Y,
  input  logic [1:0]   zoom_level,
  input  logic         frame_start,
  input  logic         out_ready,
`ifdef SCAN_ABORT_EN
  input  logic         abort,
`endif
  output logic         out_valid,
  output logic [15:0]  pixel_X,
  output logic [15:0]  pixel_Y,
  output logic [N-1:0] real_X,
  output logic [N-1:0] real_Y,
  output logic         last_pixel,
  output logic         busy,
  output logic         frame_done
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  localparam logic [N-1:0] STEP0_N = N'(STEP0);
  localparam logic [15:0]  X_LAST  = 16'(H_RES - 1);
  localparam logic [15:0]  Y_LAST  = 16'(V_RES - 1);

  // Q only documents the coordinate format; the datapath is format-agnostic.
  if (Q < 0 || Q >= N) begin : g_bad_q
    $error("pixel_scan_gen: Q must lie in [0, N)");
  end

  state_t         state_q, state_d;
  logic [15:0]    pix_x_q, pix_x_d;
  logic [15:0]    pix_y_q, pix_y_d;
  logic [N-1:0]   real_x_q, real_x_d;
  logic [N-1:0]   real_y_q, real_y_d;
  logic [N-1:0]   start_x_q, start_x_d;
  logic [N-1:0]   step_q, step_d;

  logic           at_last;
  logic           xfer;
  logic           abort_hit;

  assign at_last = (pix_x_q == X_LAST) && (pix_y_q == Y_LAST);
  assign xfer    = (state_q == SCAN) && out_ready;

`ifdef SCAN_ABORT_EN
  assign abort_hit = (state_q == SCAN) && abort;
`else
  assign abort_hit = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    pix_x_d   = pix_x_q;
    pix_y_d   = pix_y_q;
    real_x_d  = real_x_q;
    real_y_d  = real_y_q;
    start_x_d = start_x_q;
    step_d    = step_q;

    case (state_q)
      IDLE: begin
        if (frame_start) begin
          start_x_d = start_coord_X;
          step_d    = STEP0_N >> zoom_level;
          pix_x_d   = 16'd0;
          pix_y_d   = 16'd0;
          real_x_d  = start_coord_X;
          real_y_d  = start_coord_Y;
          state_d   = SCAN;
        end
      end
      SCAN: begin
        if (abort_hit) begin
          state_d = IDLE;
        end else if (xfer) begin
          if (at_last) begin
            state_d = DONE;
          end else if (pix_x_q == X_LAST) begin
            // Moving down the screen walks the imaginary axis downwards.
            pix_x_d  = 16'd0;
            real_x_d = start_x_q;
            pix_y_d  = pix_y_q + 16'd1;
            real_y_d = real_y_q - step_q;
          end else begin
            pix_x_d  = pix_x_q + 16'd1;
            real_x_d = real_x_q + step_q;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pix_x_q   <= '0;
      pix_y_q   <= '0;
      real_x_q  <= '0;
      real_y_q  <= '0;
      start_x_q <= '0;
      step_q    <= '0;
    end else begin
      state_q   <= state_d;
      pix_x_q   <= pix_x_d;
      pix_y_q   <= pix_y_d;
      real_x_q  <= real_x_d;
      real_y_q  <= real_y_d;
      start_x_q <= start_x_d;
      step_q    <= step_d;
    end
  end

  assign out_valid  = (state_q == SCAN);
  assign busy       = (state_q == SCAN) || (state_q == DONE);
  assign frame_done = (state_q == DONE);
  assign last_pixel = (state_q == SCAN) && at_last;
  assign pixel_X    = pix_x_q;
  assign pixel_Y    = pix_y_q;
  assign real_X     = real_x_q;
  assign real_Y     = real_y_q;

endmodule

// File: tb/tb_pixel_scan_gen.sv
// Directed bench for pixel_scan_gen: a full-size instance for coordinate arithmetic and a
// small 4x3 instance for whole-frame accounting.
module tb_pixel_scan_gen;

  logic        clk = 1'b0;
  logic        rst_n;

  logic [31:0] a_sx, a_sy;
  logic [1:0]  a_zoom;
  logic        a_start, a_ready;
  logic        a_valid, a_last, a_busy, a_done;
  logic [15:0] a_px, a_py;
  logic [31:0] a_rx, a_ry;

  logic [31:0] b_sx, b_sy;
  logic [1:0]  b_zoom;
  logic        b_start, b_ready;
  logic        b_valid, b_last, b_busy, b_done;
  logic [15:0] b_px, b_py;
  logic [31:0] b_rx, b_ry;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pixel_scan_gen dut_a (
    .clk(clk), .rst_n(rst_n),
    .start_coord_X(a_sx), .start_coord_Y(a_sy), .zoom_level(a_zoom),
    .frame_start(a_start), .out_ready(a_ready), .out_valid(a_valid),
    .pixel_X(a_px), .pixel_Y(a_py), .real_X(a_rx), .real_Y(a_ry),
    .last_pixel(a_last), .busy(a_busy), .frame_done(a_done)
  );

  pixel_scan_gen #(.H_RES(4), .V_RES(3)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .start_coord_X(b_sx), .start_coord_Y(b_sy), .zoom_level(b_zoom),
    .frame_start(b_start), .out_ready(b_ready), .out_valid(b_valid),
    .pixel_X(b_px), .pixel_Y(b_py), .real_X(b_rx), .real_Y(b_ry),
    .last_pixel(b_last), .busy(b_busy), .frame_done(b_done)
  );

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic [31:0] sx, input logic [31:0] sy,
                               input logic [1:0] zoom, input logic start);
    a_sx    = sx;
    a_sy    = sy;
    a_zoom  = zoom;
    a_start = start;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic checkTuple(input string tag, input logic [15:0] px, input logic [15:0] py,
                            input logic [31:0] rx, input logic [31:0] ry);
    checkOutput({tag, " valid"}, 64'(a_valid), 64'd1);
    checkOutput({tag, " pixel"}, {a_px, a_py}, {px, py});
    checkOutput({tag, " real_X"}, 64'(a_rx), 64'(rx));
    checkOutput({tag, " real_Y"}, 64'(a_ry), 64'(ry));
  endtask

  task automatic checkResetA(input string tag);
    checkOutput({tag, " flags"}, {a_valid, a_busy, a_done, a_last}, 4'b0000);
    checkOutput({tag, " pixel"}, {a_px, a_py}, 32'd0);
    checkOutput({tag, " real"}, {a_rx, a_ry}, 64'd0);
    checkOutput({tag, " step"}, 64'(dut_a.step_q), 64'd0);
  endtask

  initial begin
    int transfers, lasts, dones;
    bit done_seen;

    rst_n   = 1'b0;
    applyStimulus(32'h0, 32'h0, 2'd0, 1'b0);
    a_ready = 1'b1;
    b_sx = 32'h0000_0000; b_sy = 32'h0000_0000; b_zoom = 2'd0;
    b_start = 1'b0; b_ready = 1'b1;

    #3;
    checkResetA("reset before clock");
    tick(2);
    checkResetA("reset with clock");
    rst_n = 1'b1;
    tick(1);

    // First frame, zoom 0
    applyStimulus(32'hFFC0_0000, 32'h0024_0000, 2'd0, 1'b1);
    tick(1);
    a_start = 1'b0;
    checkTuple("first tuple", 16'd0, 16'd0, 32'hFFC0_0000, 32'h0024_0000);
    checkOutput("busy in scan", 64'(a_busy), 64'd1);
    tick(1);
    checkTuple("second tuple", 16'd1, 16'd0, 32'hFFC0_2666, 32'h0024_0000);

    // New start request and coordinates mid-frame must not disturb the frame
    applyStimulus(32'h0000_0000, 32'h1111_1111, 2'd3, 1'b1);
    tick(1);
    a_start = 1'b0;
    checkTuple("ignore start", 16'd2, 16'd0, 32'hFFC0_4CCC, 32'h0024_0000);

    tick(637);
    checkTuple("end of row 0", 16'd639, 16'd0, 32'h001F_D89A, 32'h0024_0000);
    checkOutput("no last at row end", 64'(a_last), 64'd0);
    tick(1);
    checkTuple("row wrap", 16'd0, 16'd1, 32'hFFC0_0000, 32'h0023_D99A);

    // Stall at (10,3)
    tick(1290);
    checkTuple("before stall", 16'd10, 16'd3, 32'hFFC1_7FFC, 32'h0023_8CCE);
    a_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      checkTuple("stall hold", 16'd10, 16'd3, 32'hFFC1_7FFC, 32'h0023_8CCE);
    end
    a_ready = 1'b1;
    tick(1);
    checkTuple("after stall", 16'd11, 16'd3, 32'hFFC1_A662, 32'h0023_8CCE);

    // Reset mid-frame at (100,50)
    tick(30169);
    checkTuple("before reset", 16'd100, 16'd50, 32'hFFCE_FFD8, 32'h001C_8014);
    rst_n = 1'b0;
    #1;
    checkResetA("async reset mid-frame");
    tick(2);
    checkOutput("no done in reset", 64'(a_done), 64'd0);
    rst_n = 1'b1;
    tick(1);
    checkOutput("idle after reset", {a_valid, a_busy, a_done}, 3'b000);

    // Zoom 2 frame
    applyStimulus(32'hFFC0_0000, 32'h0024_0000, 2'd2, 1'b1);
    tick(1);
    a_start = 1'b0;
    checkTuple("restart origin", 16'd0, 16'd0, 32'hFFC0_0000, 32'h0024_0000);
    checkOutput("zoom 2 step", 64'(dut_a.step_q), 64'h999);
    tick(1);
    checkTuple("zoom 2 pixel 1", 16'd1, 16'd0, 32'hFFC0_0999, 32'h0024_0000);
    applyStimulus(32'h0000_0000, 32'h0000_0000, 2'd0, 1'b0);
    tick(1);
    checkTuple("zoom change ignored", 16'd2, 16'd0, 32'hFFC0_1332, 32'h0024_0000);

    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    tick(1);

    // Whole 4x3 frame on the small instance
    b_sx = 32'h0001_0000; b_sy = 32'h0002_0000; b_zoom = 2'd1;
    b_start = 1'b1;
    tick(1);
    b_start = 1'b0;
    transfers = 0; lasts = 0; dones = 0; done_seen = 1'b0;
    for (int i = 0; i < 100 && !done_seen; i++) begin
      b_ready = (i != 5);
      b_start = (i == 3);
      if (b_last) begin
        lasts++;
        checkOutput("small last position", {b_px, b_py}, {16'd3, 16'd2});
      end
      if (b_valid && b_ready) transfers++;
      if (b_done) begin
        dones++;
        done_seen = 1'b1;
        checkOutput("busy in done", {b_busy, b_valid}, 2'b10);
      end else begin
        tick(1);
      end
    end
    b_start = 1'b0;
    b_ready = 1'b1;
    checkOutput("small transfers", 64'(transfers), 64'd12);
    checkOutput("small last count", 64'(lasts), 64'd1);
    checkOutput("small done count", 64'(dones), 64'd1);
    tick(1);
    checkOutput("done one cycle", {b_done, b_busy, b_valid}, 3'b000);
    b_start = 1'b1;
    tick(1);
    b_start = 1'b0;
    checkOutput("restart after done", {b_valid, b_px, b_py}, {1'b1, 16'd0, 16'd0});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pixel_scan_gen.md
PIXEL_SCAN_GEN -- requirements
Module: pixel_scan_gen

Interface
REQ-001 Parameter Q, default 21: fractional bits of signed fixed-point coordinates.
REQ-002 Parameter N, default 32: coordinate width.
REQ-003 Parameter H_RES, default 640: pixels per line.
REQ-004 Parameter V_RES, default 480: lines per frame.
REQ-005 Parameter STEP0, default 9830 (0x2666, 3.0/640 in Q21): real step per pixel at zoom level 0.
REQ-006 Port clk, input, 1: the only clock; all logic SHALL be on its rising edge.
REQ-007 Port rst_n, input, 1: reset, asynchronous and active-low.
REQ-008 Port start_coord_X, input, N: signed real X of the upper-left pixel.
REQ-009 Port start_coord_Y, input, N: signed real Y of the upper-left pixel.
REQ-010 Port zoom_level, input, 2: zoom level 0..3.
REQ-011 Port frame_start, input, 1: single-cycle request to scan one frame.
REQ-012 Port out_valid, output, 1: output coordinate tuple is valid.
REQ-013 Port out_ready, input, 1: the consumer accepts the tuple.
REQ-014 Port pixel_X and pixel_Y, outputs, 16 each: screen coordinates.
REQ-015 Port real_X and real_Y, outputs, N each: complex-plane coordinates of the pixel.
REQ-016 Port last_pixel, output, 1: the current tuple is (H_RES-1, V_RES-1).
REQ-017 Port busy, output, 1: a frame scan is in progress.
REQ-018 Port frame_done, output, 1: one-cycle pulse when a frame completes.

Function
REQ-019 The FSM SHALL have three states: IDLE, SCAN and DONE.
REQ-020 In IDLE with frame_start=1, the block SHALL latch start_coord_X, start_coord_Y and zoom_level, load pixel (0,0) with real=(start_X,start_Y), enter SCAN, and assert out_valid on the next cycle.
REQ-021 The step SHALL be STEP0 >> latched zoom_level (logical shift, truncating); the step SHALL be constant for the whole frame.
REQ-022 A transfer SHALL occur on a cycle with out_valid=1 and out_ready=1; after a transfer, the next tuple SHALL appear on the following cycle with no bubble.
REQ-023 When out_valid=1 and out_ready=0, all outputs SHALL hold their values.
REQ-024 On a transfer with pixel_X < H_RES-1: pixel_X+1 and real_X+step.
REQ-025 On a transfer with pixel_X = H_RES-1 (row wrap): pixel_X=0, real_X=latched start_X, pixel_Y+1, real_Y-step (screen down equals imaginary decreasing).
REQ-026 The real-coordinate addition and subtraction SHALL be N-bit two's complement, wrapping modulo 2^N with no saturation.
REQ-027 A transfer with last_pixel=1 SHALL enter DONE and deassert out_valid the next cycle; DONE SHALL pulse frame_done for exactly one cycle and then return to IDLE.
REQ-028 busy SHALL be 1 in SCAN and DONE.
REQ-029 frame_start SHALL be ignored outside IDLE, and SHALL be accepted on the cycle after frame_done.
REQ-030 Changes on start_coord_X, start_coord_Y or zoom_level during a frame SHALL NOT affect the frame in progress.

Reset
REQ-031 While rst_n=0, the block SHALL be in IDLE with out_valid, busy, frame_done and last_pixel at 0, pixel_X and pixel_Y at 0, real_X and real_Y at 0, and the latched step at 0, regardless of the clock.
REQ-032 Reset mid-frame SHALL abandon the frame with no frame_done pulse.

Configuration
REQ-033 When SCAN_ABORT_EN is defined, an input port abort (1 bit) SHALL exist; abort=1 in SCAN SHALL force IDLE on the next edge with out_valid=0 and no frame_done pulse; abort SHALL have priority over a simultaneous transfer.
REQ-034 When SCAN_ABORT_EN is undefined, the abort port SHALL be absent, and a frame SHALL end only by completion or reset.

Verification
REQ-035 Defaults, start_X=0xFFC00000, start_Y=0x00240000, zoom 0, out_ready=1, frame_start pulse -> first tuple (0,0,0xFFC00000,0x00240000); second tuple real_X=0xFFC02666.
REQ-036 Same setup, transfer of (639,0) -> next tuple (0,1), real_X=0xFFC00000, real_Y=0x0023D99A.
REQ-037 zoom_level=2 -> step 0x999; pixel (1,0) real_X=0xFFC00999; changing zoom_level mid-frame -> step unchanged.
REQ-038 out_ready held 0 for 5 cycles at (10,3) -> all outputs stable; on release, exactly one transfer of (10,3).
REQ-039 Full frame -> exactly 307200 transfers, last_pixel only on (639,479), one frame_done pulse, and frame_start during the frame ignored.
REQ-040 rst_n low at pixel (100,50) -> outputs at reset values immediately; no frame_done; a new frame_start restarts at (0,0).
